// File: rtl/id_operand_stage.sv
// id_operand_stage: IF/ID pipeline register, instruction hold buffer, priority operand
// bypass with $zero protection, load-use interlock and saturating stall counter.
module id_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 16
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall_id,
  input  logic                      if_valid,
  input  logic [PC_W-1:0]           if_pc,
  input  logic [31:0]               inst_in,
  input  logic                      use_rs,
  input  logic                      use_rt,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  output logic [REG_AW-1:0]         rf_raddr1,
  output logic [REG_AW-1:0]         rf_raddr2,
  output logic                      id_valid,
  output logic [PC_W-1:0]           id_pc,
  output logic [31:0]               id_inst,
  output logic [DATA_W-1:0]         rdata1,
  output logic [DATA_W-1:0]         rdata2,
  output logic                      stallreq,
  output logic [CNT_W-1:0]          stall_cycles
);
  typedef enum logic {LIVE, HELD} state_t;
  state_t state;
  logic valid_r;
  logic [PC_W-1:0] pc_r;
  logic [31:0] hold_inst;
  logic [REG_AW-1:0] rs, rt;
  logic ld1, ld2;
  assign id_inst = state == HELD ? hold_inst : inst_in;
  assign rs = id_inst[25:21];
  assign rt = id_inst[20:16];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;
  assign id_pc = pc_r;
  assign id_valid = valid_r & ~stall_id & ~stallreq;
  // Walk oldest to youngest so the lowest matching index wins; the winner's load flag decides the interlock.
  always_comb begin
    rdata1 = rf_rdata1;
    rdata2 = rf_rdata2;
    ld1 = 1'b0;
    ld2 = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && fwd_waddr[i*REG_AW +: REG_AW] == rs) begin
        rdata1 = fwd_wdata[i*DATA_W +: DATA_W];
        ld1 = fwd_is_load[i];
      end
      if (fwd_we[i] && fwd_waddr[i*REG_AW +: REG_AW] == rt) begin
        rdata2 = fwd_wdata[i*DATA_W +: DATA_W];
        ld2 = fwd_is_load[i];
      end
    end
    if (rs == '0) begin
      rdata1 = '0;
      ld1 = 1'b0;
    end
    if (rt == '0) begin
      rdata2 = '0;
      ld2 = 1'b0;
    end
  end
  assign stallreq = valid_r & ~flush & ((use_rs & ld1) | (use_rt & ld2));
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      pc_r <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (!stall_id) begin
      valid_r <= if_valid;
      pc_r <= if_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LIVE;
      hold_inst <= '0;
    end else if (state == LIVE) begin
      if (stall_id && !flush) begin
        state <= HELD;
        hold_inst <= inst_in;
      end
    end else if (!stall_id || flush) begin
      state <= LIVE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (stallreq && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed vectors push expected outputs into a queue; a negedge monitor pops and compares.
module tb_id_operand_stage;
  logic clk = 0, rst, flush, stall_id, if_valid, use_rs, use_rt;
  logic [31:0] if_pc, inst_in, rf_rdata1, rf_rdata2;
  logic [2:0] fwd_we, fwd_is_load;
  logic [14:0] fwd_waddr;
  logic [95:0] fwd_wdata;
  logic [4:0] rf_raddr1, rf_raddr2;
  logic id_valid, stallreq;
  logic [31:0] id_pc, id_inst, rdata1, rdata2;
  logic [3:0] stall_cycles;
  typedef struct {
    string name;
    logic [6:0] m;
    logic v;
    logic [31:0] pc, inst, r1, r2;
    logic sr;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, errors = 0;
  localparam logic [6:0] M_ALL = 7'h7f, M_NOOP = 7'h67;
  id_operand_stage #(.DATA_W(32), .PC_W(32), .REG_AW(5), .NUM_FWD(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id), .if_valid(if_valid), .if_pc(if_pc),
    .inst_in(inst_in), .use_rs(use_rs), .use_rt(use_rt), .fwd_we(fwd_we), .fwd_is_load(fwd_is_load),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .rdata1(rdata1), .rdata2(rdata2), .stallreq(stallreq), .stall_cycles(stall_cycles)
  );
  always #5 clk = ~clk;
  task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", n, f, act, req);
    end
  endtask
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.m[0]) cmp(e.name, "id_valid", 32'(id_valid), 32'(e.v));
      if (e.m[1]) cmp(e.name, "id_pc", id_pc, e.pc);
      if (e.m[2]) cmp(e.name, "id_inst", id_inst, e.inst);
      if (e.m[3]) cmp(e.name, "rdata1", rdata1, e.r1);
      if (e.m[4]) cmp(e.name, "rdata2", rdata2, e.r2);
      if (e.m[5]) cmp(e.name, "stallreq", 32'(stallreq), 32'(e.sr));
      if (e.m[6]) cmp(e.name, "stall_cycles", 32'(stall_cycles), 32'(e.cnt));
    end
  end
  task automatic chk(string n, logic [6:0] m, logic v, logic [31:0] pc, logic [31:0] inst,
                     logic [31:0] r1, logic [31:0] r2, logic sr, logic [3:0] cnt);
    q.push_back('{n, m, v, pc, inst, r1, r2, sr, cnt});
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic setf(logic [2:0] we, logic [2:0] ld, logic [14:0] a, logic [95:0] d);
    fwd_we = we;
    fwd_is_load = ld;
    fwd_waddr = a;
    fwd_wdata = d;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired with %0d expectations pending", q.size());
    $fatal(1);
  end
  initial begin
    rst = 1; flush = 0; stall_id = 0; if_valid = 0; if_pc = 0; inst_in = 0;
    use_rs = 0; use_rt = 0; rf_rdata1 = 32'h55; rf_rdata2 = 32'h66;
    setf(3'b000, 3'b000, 15'd0, 96'd0);
    tick(); tick();
    rst = 0;
    chk("reset", M_ALL, 0, 0, 0, 0, 0, 0, 0);
    if_valid = 1; if_pc = 32'hBFC00000;
    tick();
    inst_in = 32'h3C011234;
    chk("fetch", M_ALL, 1, 32'hBFC00000, 32'h3C011234, 0, 32'h66, 0, 0);
    tick();
    inst_in = 32'h01001820; use_rs = 1;
    setf(3'b101, 3'b000, {5'd8, 5'd0, 5'd8}, {32'h22, 32'h0, 32'h11});
    chk("fwd_pri0", M_ALL, 1, 32'hBFC00000, 32'h01001820, 32'h11, 0, 0, 0);
    tick();
    fwd_we = 3'b100;
    chk("fwd_pri2", M_ALL, 1, 32'hBFC00000, 32'h01001820, 32'h22, 0, 0, 0);
    tick();
    fwd_we = 3'b000;
    chk("fwd_none", M_ALL, 1, 32'hBFC00000, 32'h01001820, 32'h55, 0, 0, 0);
    tick();
    inst_in = 32'h00000000; use_rt = 1;
    setf(3'b001, 3'b001, 15'd0, {64'd0, 32'hDEAD});
    chk("zero_reg", M_ALL, 1, 32'hBFC00000, 0, 0, 0, 0, 0);
    tick();
    inst_in = 32'h01091820;
    setf(3'b101, 3'b100, {5'd9, 5'd0, 5'd9}, {32'h22, 32'h0, 32'h33});
    chk("young_wins", M_ALL, 1, 32'hBFC00000, 32'h01091820, 32'h55, 32'h33, 0, 0);
    tick();
    setf(3'b001, 3'b001, {5'd0, 5'd0, 5'd9}, {64'd0, 32'h44});
    stall_id = 1;
    chk("load_use", M_NOOP, 0, 32'hBFC00000, 32'h01091820, 0, 0, 1, 0);
    tick();
    inst_in = 32'hFFFFFFFF; stall_id = 0;
    setf(3'b000, 3'b000, 15'd0, 96'd0);
    chk("held_word", M_ALL, 1, 32'hBFC00000, 32'h01091820, 32'h55, 32'h66, 0, 1);
    tick();
    chk("released", M_ALL, 1, 32'hBFC00000, 32'hFFFFFFFF, 32'h55, 32'h66, 0, 1);
    tick();
    inst_in = 32'h01091820; stall_id = 1;
    chk("hold_in", M_ALL, 0, 32'hBFC00000, 32'h01091820, 32'h55, 32'h66, 0, 1);
    tick();
    inst_in = 32'hAAAAAAAA; flush = 1;
    chk("flush_held", M_ALL, 0, 32'hBFC00000, 32'h01091820, 32'h55, 32'h66, 0, 1);
    tick();
    flush = 0; stall_id = 0; inst_in = 32'h12345678;
    chk("after_flush", M_ALL, 0, 32'hBFC00000, 32'h12345678, 32'h55, 32'h66, 0, 1);
    tick();
    chk("refill", M_ALL, 1, 32'hBFC00000, 32'h12345678, 32'h55, 32'h66, 0, 1);
    tick();
    stall_id = 1;
    tick();
    inst_in = 32'h0BADBEEF; rst = 1;
    tick();
    rst = 0; stall_id = 0;
    chk("rst_held", M_ALL, 0, 0, 32'h0BADBEEF, 32'h55, 32'h66, 0, 0);
    tick();
    inst_in = 32'h01091820;
    setf(3'b001, 3'b001, {5'd0, 5'd0, 5'd9}, {64'd0, 32'h44});
    chk("sat_start", M_NOOP, 0, 32'hBFC00000, 32'h01091820, 0, 0, 1, 0);
    repeat (3) tick();
    chk("sat_count3", M_NOOP, 0, 32'hBFC00000, 32'h01091820, 0, 0, 1, 3);
    repeat (18) tick();
    chk("sat_top", M_NOOP, 0, 32'hBFC00000, 32'h01091820, 0, 0, 1, 4'hF);
    tick();
    setf(3'b000, 3'b000, 15'd0, 96'd0);
    chk("sat_hold", M_ALL, 1, 32'hBFC00000, 32'h01091820, 32'h55, 32'h66, 0, 4'hF);
    tick();
    tick();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
